// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle for piso_serializer. The producer and serial sink
// drive the master side; the serializer sits on the slave side.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic             in_ready;
  logic             msb_first;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, in_valid, msb_first, shift_en,
    input  in_ready, sout, sout_valid, sout_first, sout_last, busy
  );

  modport slave (
    input  din, in_valid, msb_first, shift_en,
    output in_ready, sout, sout_valid, sout_first, sout_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: WIDTH-bit words in over valid/ready,
// one bit out per shift_en pulse, bit order chosen per word, back-to-back capable.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             mode_r, mode_s;
  logic             last_s;
  logic             ready_s;
  logic             load_s;

  // State, shift register, bit index and latched bit order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
    end
  end

  // Handshake and next-state: a load may coincide with the last-bit pulse.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    last_s  = (cnt_r == LAST_IDX);
    ready_s = rst && ((state_r == IDLE) || ((state_r == SHIFT) && bus.shift_en && last_s));
    load_s  = ready_s && bus.in_valid;

    case (state_r)
      IDLE: begin
        if (load_s) begin
          state_s = SHIFT;
          shreg_s = bus.din;
          mode_s  = bus.msb_first;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (!bus.shift_en) begin
          state_s = SHIFT;
        end else if (!last_s) begin
          cnt_s = cnt_r + CNT_W'(1);
          if (mode_r) begin
            shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
          end else begin
            shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
          end
        end else if (load_s) begin
          state_s = SHIFT;
          shreg_s = bus.din;
          mode_s  = bus.msb_first;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_s = IDLE;
        shreg_s = {WIDTH{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
        mode_s  = 1'b0;
      end
    endcase
  end

  // Serial outputs come only from registered state, never from din.
  assign bus.in_ready   = ready_s;
  assign bus.busy       = (state_r == SHIFT);
  assign bus.sout_valid = (state_r == SHIFT);
  assign bus.sout       = (state_r == SHIFT) ? (mode_r ? shreg_r[WIDTH-1] : shreg_r[0]) : 1'b0;
  assign bus.sout_first = (state_r == SHIFT) && (cnt_r == {CNT_W{1'b0}});
  assign bus.sout_last  = (state_r == SHIFT) && last_s;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboarded bench: a 4-bit and an 8-bit serializer share clock and reset;
// directed words push hand-computed bit sequences, monitors compare at negedge.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(4)) b4 ();
  piso_serializer_if #(.WIDTH(8)) b8 ();

  piso_serializer #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  piso_serializer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  typedef struct {
    logic b;
    logic f;
    logic l;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // seq holds the bits in transmit order, leftmost first
  task automatic exp4(input logic [3:0] seq);
    for (int i = 3; i >= 0; i--) q4.push_back('{seq[i], (i == 3), (i == 0)});
  endtask

  task automatic exp8(input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) q8.push_back('{seq[i], (i == 7), (i == 0)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4-bit instance: compare the head every valid cycle, pop when consumed.
  always @(negedge clk) begin
    exp_t e;
    if (rst && b4.sout_valid) begin
      if (q4.size() == 0) begin
        chk("w4_unexpected_bit", 1, 0);
      end else begin
        e = q4[0];
        chk("w4_sout", int'(b4.sout), int'(e.b));
        chk("w4_first", int'(b4.sout_first), int'(e.f));
        chk("w4_last", int'(b4.sout_last), int'(e.l));
        if (b4.shift_en) e = q4.pop_front();
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst && b8.sout_valid) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_bit", 1, 0);
      end else begin
        e = q8[0];
        chk("w8_sout", int'(b8.sout), int'(e.b));
        chk("w8_first", int'(b8.sout_first), int'(e.f));
        chk("w8_last", int'(b8.sout_last), int'(e.l));
        if (b8.shift_en) e = q8.pop_front();
      end
    end
  end

  initial begin
    b4.din = 4'h0; b4.in_valid = 1'b0; b4.msb_first = 1'b0; b4.shift_en = 1'b0;
    b8.din = 8'h00; b8.in_valid = 1'b0; b8.msb_first = 1'b0; b8.shift_en = 1'b0;

    // reset and idle
    #3;
    chk("rst_in_ready4", int'(b4.in_ready), 0);
    chk("rst_in_ready8", int'(b8.in_ready), 0);
    chk("rst_busy8", int'(b8.busy), 0);
    chk("rst_sout_valid8", int'(b8.sout_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("idle_in_ready4", int'(b4.in_ready), 1);
    chk("idle_in_ready8", int'(b8.in_ready), 1);
    chk("idle_busy4", int'(b4.busy), 0);
    chk("idle_sout4", int'(b4.sout), 0);
    chk("idle_sout_valid4", int'(b4.sout_valid), 0);

    // MSB-first 1010 on the 4-bit instance
    b4.din = 4'b1010; b4.msb_first = 1'b1; b4.in_valid = 1'b1; b4.shift_en = 1'b1;
    exp4(4'b1010);
    tick();
    b4.in_valid = 1'b0;
    #1 chk("msb_busy_after_load", int'(b4.busy), 1);
    repeat (4) tick();
    #1 chk("msb_idle_after", int'(b4.busy), 0);
    chk("msb_ready_after", int'(b4.in_ready), 1);

    // LSB-first B4 on the 8-bit instance, msb_first toggling mid-word
    b8.din = 8'hB4; b8.msb_first = 1'b0; b8.in_valid = 1'b1; b8.shift_en = 1'b1;
    exp8(8'b00101101);
    tick();
    b8.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b8.msb_first = ~b8.msb_first;
      tick();
    end
    #1 chk("lsb_idle_after", int'(b8.busy), 0);

    // back-to-back C then 3 with in_valid held
    b4.din = 4'hC; b4.msb_first = 1'b1; b4.in_valid = 1'b1; b4.shift_en = 1'b1;
    exp4(4'b1100);
    exp4(4'b0011);
    #1 chk("b2b_ready_idle", int'(b4.in_ready), 1);
    tick();
    b4.din = 4'h3;
    for (int i = 0; i < 4; i++) begin
      #1 chk("b2b_ready_word1", int'(b4.in_ready), (i == 3) ? 1 : 0);
      chk("b2b_valid_word1", int'(b4.sout_valid), 1);
      tick();
    end
    b4.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("b2b_valid_word2", int'(b4.sout_valid), 1);
      tick();
    end
    #1 chk("b2b_idle_after", int'(b4.busy), 0);

    // paced shifting: one pulse every third cycle, second word offered mid-word
    b4.din = 4'b0110; b4.msb_first = 1'b1; b4.in_valid = 1'b1; b4.shift_en = 1'b0;
    exp4(4'b0110);
    exp4(4'b1001);
    tick();
    b4.in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      b4.shift_en = ((c % 3) == 2);
      if (c == 4) begin
        b4.din = 4'b1001; b4.msb_first = 1'b0; b4.in_valid = 1'b1;
      end
      #1 chk("paced_ready", int'(b4.in_ready), (c == 11) ? 1 : 0);
      chk("paced_busy", int'(b4.busy), 1);
      tick();
    end
    b4.in_valid = 1'b0;
    b4.shift_en = 1'b1;
    repeat (4) tick();
    #1 chk("paced_idle_after", int'(b4.busy), 0);

    // reset mid-word after three bits of FF, then a clean 01
    b8.din = 8'hFF; b8.msb_first = 1'b1; b8.in_valid = 1'b1; b8.shift_en = 1'b1;
    exp8(8'hFF);
    tick();
    b8.in_valid = 1'b0;
    repeat (3) tick();
    #1 rst = 1'b0;
    #1;
    chk("midrst_sout", int'(b8.sout), 0);
    chk("midrst_valid", int'(b8.sout_valid), 0);
    chk("midrst_first", int'(b8.sout_first), 0);
    chk("midrst_last", int'(b8.sout_last), 0);
    chk("midrst_busy", int'(b8.busy), 0);
    chk("midrst_ready", int'(b8.in_ready), 0);
    chk("midrst_bits_left", q8.size(), 5);
    q8.delete();
    tick();
    rst = 1'b1;
    #1 chk("postrst_ready", int'(b8.in_ready), 1);
    b8.din = 8'h01; b8.msb_first = 1'b1; b8.in_valid = 1'b1;
    exp8(8'b00000001);
    tick();
    b8.in_valid = 1'b0;
    repeat (8) tick();
    #1 chk("postrst_idle_after", int'(b8.busy), 0);

    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
